// File: rtl/matrix_result_reader.sv
// Result-RAM read-out: fetches N*N entries row-major and shows value/index on six 7-seg digits.
// Scrolls automatically every DWELL+2 cycles, or one entry per step pulse in manual mode.
module matrix_result_reader #(
   parameter int N     = 4,
   parameter int W     = 16,
   parameter int DWELL = 50_000_000,
   parameter int AW    = $clog2(N*N)
) (
   input  logic          clock,
   input  logic          resetN,
   input  logic          start,
   input  logic          disp_sel,
   input  logic          step,
   output logic          rd_en,
   output logic [AW-1:0] rd_addr,
   input  logic [W-1:0]  rd_data,
   output logic          busy,
   output logic [6:0]    HEX0,
   output logic [6:0]    HEX1,
   output logic [6:0]    HEX2,
   output logic [6:0]    HEX3,
   output logic [6:0]    HEX4,
   output logic [6:0]    HEX5
);

   localparam int              CW      = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [AW-1:0]   LAST    = AW'(N*N-1);
   localparam logic [CW-1:0]   CNT_END = CW'(DWELL-1);
   localparam logic [6:0]      BLANK   = 7'h7F;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, SHOW} state_t;

   state_t        state, state_nx;
   logic [AW-1:0] idx;
   logic [CW-1:0] cnt;
   logic          start_low_q;   // previous start sample was low; 0 after reset so a held start cannot launch
   logic          sel_q;
   logic          launch, sel_chg;
   logic          adv, latch, cnt_clr, cnt_inc;
   logic [15:0]   val_ext;
   logic [7:0]    idx_ext;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      unique case (d)
         4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
         4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
         4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
         4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
      endcase
      return s;
   endfunction

   assign launch  = start & start_low_q;
   assign sel_chg = disp_sel ^ sel_q;
   assign rd_en   = (state == REQ);
   assign rd_addr = idx;
   assign busy    = (state != IDLE);
   assign val_ext = 16'(rd_data);
   assign idx_ext = 8'(idx);

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) state <= IDLE;
      else         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      adv      = 1'b0;
      latch    = 1'b0;
      cnt_clr  = 1'b0;
      cnt_inc  = 1'b0;
      case (state)
         IDLE: if (launch) state_nx = REQ;
         REQ:  state_nx = WAIT;
         WAIT: begin
            latch    = 1'b1;
            cnt_clr  = 1'b1;
            state_nx = SHOW;
         end
         SHOW: begin
            if (disp_sel) begin
               cnt_clr = sel_chg;
               if (step) begin
                  adv      = 1'b1;
                  state_nx = REQ;
               end
            end else if (sel_chg) begin
               // switching back to auto restarts the dwell for the entry on display
               cnt_clr = 1'b1;
            end else if (cnt == CNT_END) begin
               adv      = 1'b1;
               state_nx = REQ;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         start_low_q <= 1'b0;
         sel_q       <= 1'b0;
         idx         <= '0;
         cnt         <= '0;
         HEX0        <= BLANK;
         HEX1        <= BLANK;
         HEX2        <= BLANK;
         HEX3        <= BLANK;
         HEX4        <= BLANK;
         HEX5        <= BLANK;
      end else begin
         start_low_q <= ~start;
         sel_q       <= disp_sel;
         if (adv) idx <= (idx == LAST) ? '0 : idx + AW'(1);
         if (cnt_clr)      cnt <= '0;
         else if (cnt_inc) cnt <= cnt + CW'(1);
         if (latch) begin
            HEX0 <= seg7(val_ext[3:0]);
            HEX1 <= seg7(val_ext[7:4]);
            HEX2 <= seg7(val_ext[11:8]);
            HEX3 <= seg7(val_ext[15:12]);
            HEX4 <= seg7(idx_ext[3:0]);
            HEX5 <= seg7(idx_ext[7:4]);
         end
      end
   end

endmodule

// File: tb/tb_matrix_result_reader.sv
// Directed + randomized bench for matrix_result_reader (N=2, DWELL=4) with a 1-cycle RAM model.
module tb_matrix_result_reader;

   localparam int N     = 2;
   localparam int W     = 16;
   localparam int DWELL = 4;
   localparam int AW    = $clog2(N*N);
   localparam logic [41:0] BLANK = {6{7'h7F}};

   logic          clock = 1'b0;
   logic          resetN = 1'b0;
   logic          start = 1'b0;
   logic          disp_sel = 1'b0;
   logic          step = 1'b0;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [W-1:0]  rd_data;
   logic          busy;
   logic [6:0]    HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
   logic [41:0]   hex_all;

   logic [15:0]   mem [N*N];
   logic [6:0]    seg_tab [16];
   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   int            last_req = 0;
   int            exp_idx = 0;

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;
   always @(posedge clock) if (rd_en) rd_data <= mem[rd_addr];

   assign hex_all = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

   matrix_result_reader #(.N(N), .W(W), .DWELL(DWELL)) dut (
      .clock(clock), .resetN(resetN), .start(start), .disp_sel(disp_sel), .step(step),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy),
      .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected display for entry i: index byte on HEX5..4, value nibbles on HEX3..0.
   function automatic logic [41:0] exp_hex(input int i);
      logic [15:0] v;
      v = mem[i];
      return {seg_tab[(i >> 4) & 15], seg_tab[i & 15],
              seg_tab[v[15:12]], seg_tab[v[11:8]], seg_tab[v[7:4]], seg_tab[v[3:0]]};
   endfunction

   task automatic wait_req(output int n);
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!rd_en && n < 50);
      check("req_seen", rd_en, 1'b1);
   endtask

   // One auto-mode entry: REQ spacing, address, single-cycle rd_en, then the display.
   task automatic auto_entry(input int a);
      int n;
      wait_req(n);
      check("auto_period", cyc - last_req, DWELL + 2);
      check("auto_addr", rd_addr, a);
      last_req = cyc;
      @(negedge clock);
      check("rd_en_one_cycle", rd_en, 1'b0);
      @(negedge clock);
      check("auto_hex", hex_all, exp_hex(a));
   endtask

   task automatic manual_step();
      step = 1'b1;
      @(negedge clock);
      step = 1'b0;
      exp_idx = (exp_idx + 1) % (N*N);
      check("step_rd_en", rd_en, 1'b1);
      check("step_addr", rd_addr, exp_idx);
      @(negedge clock);
      @(negedge clock);
      check("step_hex", hex_all, exp_hex(exp_idx));
   endtask

   initial begin
      int n;
      int rd_cnt;
      int busy_cnt;
      seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      mem = '{16'h1234, 16'hABCD, 16'h0007, 16'hFFFF};

      // reset state, and it holds with start low
      repeat (3) @(negedge clock);
      check("rst_hex", hex_all, BLANK);
      check("rst_busy", busy, 1'b0);
      check("rst_rd_en", rd_en, 1'b0);
      check("rst_addr", rd_addr, 0);
      resetN = 1'b1;
      repeat (5) @(negedge clock);
      check("idle_hex", hex_all, BLANK);
      check("idle_busy", busy, 1'b0);
      check("idle_rd_en", rd_en, 1'b0);

      // launch: REQ then WAIT, display appears two edges after the launch edge
      start = 1'b1;
      @(negedge clock);
      check("launch_rd_en", rd_en, 1'b1);
      check("launch_addr", rd_addr, 0);
      check("launch_busy", busy, 1'b1);
      check("launch_hex_blank", hex_all, BLANK);
      last_req = cyc;
      @(negedge clock);
      check("wait_rd_en", rd_en, 1'b0);
      check("wait_hex_blank", hex_all, BLANK);
      @(negedge clock);
      check("e0_hex", hex_all, {7'h40, 7'h40, 7'h79, 7'h24, 7'h30, 7'h19});

      // auto scroll through all entries and wrap to 0
      for (int e = 1; e <= N*N; e++) begin
         auto_entry(e % (N*N));
         if (e == 3) begin
            check("ffff_hex", hex_all[27:0], {4{7'h0E}});
            check("idx3_hex4", HEX4, 7'h30);
         end
      end

      // manual mode: hold, step, step ignored during REQ/WAIT, random step spacing
      disp_sel = 1'b1;
      exp_idx = 0;
      rd_cnt = 0;
      repeat (100) begin
         @(negedge clock);
         if (rd_en) rd_cnt++;
      end
      check("manual_hold", rd_cnt, 0);
      check("manual_hex", hex_all, exp_hex(0));
      step = 1'b1;
      @(negedge clock);
      exp_idx = 1;
      check("step_rd_en", rd_en, 1'b1);
      check("step_addr", rd_addr, exp_idx);
      @(negedge clock);
      @(negedge clock);
      step = 1'b0;
      check("step_ign_hex", hex_all, exp_hex(exp_idx));
      rd_cnt = 0;
      repeat (20) begin
         @(negedge clock);
         if (rd_en) rd_cnt++;
      end
      check("step_ignored", rd_cnt, 0);
      repeat (4) begin
         repeat ($urandom_range(1, 12)) @(negedge clock);
         manual_step();
      end

      // async reset between edges blanks at once; held start must not relaunch
      #2 resetN = 1'b0;
      #1;
      check("async_hex", hex_all, BLANK);
      check("async_busy", busy, 1'b0);
      check("async_rd_en", rd_en, 1'b0);
      check("async_addr", rd_addr, 0);
      disp_sel = 1'b0;
      @(negedge clock);
      resetN = 1'b1;
      rd_cnt = 0;
      busy_cnt = 0;
      repeat (10) begin
         @(negedge clock);
         if (rd_en) rd_cnt++;
         if (busy) busy_cnt++;
      end
      check("held_start_rd", rd_cnt, 0);
      check("held_start_busy", busy_cnt, 0);
      foreach (mem[i]) mem[i] = 16'($urandom);
      start = 1'b0;
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      check("relaunch_rd_en", rd_en, 1'b1);
      check("relaunch_addr", rd_addr, 0);
      last_req = cyc;
      @(negedge clock);
      @(negedge clock);
      check("relaunch_hex", hex_all, exp_hex(0));

      // start edge while busy is ignored; disp_sel toggle restarts the dwell
      start = 1'b0;
      @(negedge clock);
      start = 1'b1;
      disp_sel = 1'b1;
      @(negedge clock);
      disp_sel = 1'b0;
      wait_req(n);
      check("toggle_dwell", n, DWELL + 1);
      check("toggle_addr", rd_addr, 1);
      last_req = cyc;
      @(negedge clock);
      @(negedge clock);
      check("toggle_hex", hex_all, exp_hex(1));
      for (int e = 2; e <= N*N + 1; e++) auto_entry(e % (N*N));
      check("still_busy", busy, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

endmodule
